count_sequencer: RTL and testbench

- Run-control sequencer for the 3-bit toggle-FF counter datapath.
- Replaces free-running clock division with a single-clock tick enable, so all state stays in the `clk` domain.
- Sequences the count through start/hold/stop/load commands toward a programmable terminal value, in one-shot or auto-reload mode.
- Sits between the board switch/button logic and the counter/display path.

---
 rtl/count_sequencer_pkg.sv | 20 ++
 rtl/count_sequencer_if.sv | 43 ++++
 rtl/count_sequencer_tick_gen.sv | 38 +++
 rtl/count_sequencer.sv | 137 +++++++++++++
 tb/tb_count_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/count_sequencer_pkg.sv
// Shared types and defaults for the count sequencer.
// Optional sticky interrupt: define COUNT_SEQUENCER_IRQ_EN.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_DIV   = 2;

  // A DIV of 1 still needs a one-bit divider register.
  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/count_sequencer_if.sv
// Command/status bundle between the switch logic and the count sequencer.
// COUNT_SEQUENCER_IRQ_EN adds the irq_clr/irq pair.
interface count_sequencer_if
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic             stop;
  logic             hold;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term_val;
  logic             auto_rld;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;
`ifdef COUNT_SEQUENCER_IRQ_EN
  logic             irq_clr;
  logic             irq;

  modport master (
    output start, stop, hold, load, load_val, term_val, auto_rld, irq_clr,
    input  count, busy, done, wrap, irq
  );
  modport slave (
    input  start, stop, hold, load, load_val, term_val, auto_rld, irq_clr,
    output count, busy, done, wrap, irq
  );
`else
  modport master (
    output start, stop, hold, load, load_val, term_val, auto_rld,
    input  count, busy, done, wrap
  );
  modport slave (
    input  start, stop, hold, load, load_val, term_val, auto_rld,
    output count, busy, done, wrap
  );
`endif

endinterface

// File: rtl/count_sequencer_tick_gen.sv
// DIV-modulo tick divider with enable and synchronous clear.
module count_sequencer_tick_gen
  import count_sequencer_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic RST,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DW = div_width(DIV);

  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == DW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run-control sequencer: start/hold/stop/load toward a terminal count.
// Define COUNT_SEQUENCER_IRQ_EN for a sticky irq on every done/wrap pulse.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input logic              clk,
  input logic              RST,
  count_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             div_en;
  logic             div_clr;
  logic             tick;
  logic             term_hit;

  count_sequencer_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .RST    (RST),
    .en_i   (div_en),
    .clr_i  (div_clr),
    .tick_o (tick)
  );

  assign term_hit = tick && (count_q == bus.term_val);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (!bus.load && bus.start) state_d = RUN;
        RUN: begin
          if (bus.hold)                       state_d = HOLD;
          else if (term_hit && !bus.auto_rld) state_d = DONE;
        end
        HOLD: if (!bus.hold) state_d = RUN;
        DONE: begin
          if (bus.load)       state_d = IDLE;
          else if (bus.start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The divider is held clear outside RUN/HOLD so every entry into RUN starts at phase 0.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    div_en  = 1'b0;
    div_clr = 1'b0;
    if (bus.stop) begin
      count_d = '0;
      div_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          div_clr = 1'b1;
          if (bus.load) count_d = bus.load_val;
        end
        RUN: begin
          if (!bus.hold) begin
            div_en = 1'b1;
            if (term_hit) begin
              if (bus.auto_rld) begin
                count_d = '0;
                wrap_d  = !wrap_q;
              end else begin
                done_d  = 1'b1;
              end
            end else if (tick) begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        HOLD: if (bus.load) count_d = bus.load_val;
        DONE: begin
          div_clr = 1'b1;
          if (bus.load)       count_d = bus.load_val;
          else if (bus.start) count_d = '0;
        end
        default: div_clr = 1'b1;
      endcase
    end
    busy_d = (state_d == RUN) || (state_d == HOLD);
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.wrap  = wrap_q;

`ifdef COUNT_SEQUENCER_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      irq_q <= 1'b0;
    end else if (done_d || wrap_d) begin
      irq_q <= 1'b1;
    end else if (bus.irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: DIV=2 vector table plus DIV=1, async reset and irq sequences.
module tb_count_sequencer;

  logic clk;
  logic RST;

  count_sequencer_if #(.WIDTH(3)) if_a ();
  count_sequencer_if #(.WIDTH(3)) if_b ();

  count_sequencer #(.WIDTH(3), .DIV(2)) dut_a (.clk(clk), .RST(RST), .bus(if_a));
  count_sequencer #(.WIDTH(3), .DIV(1)) dut_b (.clk(clk), .RST(RST), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start, stop, hold, load;
    logic [2:0] load_val, term_val;
    logic       auto_rld;
    logic [2:0] e_count;
    logic       e_busy, e_done, e_wrap;
  } vec_t;

  vec_t vecs[$];
  int   n_chk;
  int   n_fail;

  task automatic add(input logic st, sp, hd, ld, input logic [2:0] lv, tv, input logic ar,
                     input logic [2:0] ec, input logic eb, ed, ew);
    vec_t v;
    v.start = st; v.stop = sp; v.hold = hd; v.load = ld;
    v.load_val = lv; v.term_val = tv; v.auto_rld = ar;
    v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input int c, input int b, input int d, input int w);
    chk({nm, ".count"}, int'(if_a.count), c);
    chk({nm, ".busy"},  int'(if_a.busy),  b);
    chk({nm, ".done"},  int'(if_a.done),  d);
    chk({nm, ".wrap"},  int'(if_a.wrap),  w);
  endtask

  task automatic idle_a();
    if_a.start = 0; if_a.stop = 0; if_a.hold = 0; if_a.load = 0;
    if_a.load_val = 0; if_a.term_val = 3'd5; if_a.auto_rld = 0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    RST = 1'b1;
    idle_a();
    if_b.start = 0; if_b.stop = 0; if_b.hold = 0; if_b.load = 0;
    if_b.load_val = 0; if_b.term_val = 3'd7; if_b.auto_rld = 1;
`ifdef COUNT_SEQUENCER_IRQ_EN
    if_a.irq_clr = 0;
    if_b.irq_clr = 0;
`endif

    // st sp hd ld lv tv ar | count busy done wrap
    add(0,0,0,0,0,5,0, 0,0,0,0);
    add(0,0,0,1,6,5,0, 6,0,0,0);   // load in IDLE
    add(1,0,0,1,6,5,0, 6,0,0,0);   // load beats start
    add(0,1,0,0,0,5,0, 0,0,0,0);
    add(1,0,0,0,0,5,0, 0,1,0,0);   // start accepted (edge N)
    add(0,0,0,0,0,5,0, 0,1,0,0);
    add(0,0,0,0,0,5,0, 1,1,0,0);
    add(0,0,0,0,0,5,0, 1,1,0,0);
    add(0,0,0,0,0,5,0, 2,1,0,0);
    add(0,0,0,1,6,5,0, 2,1,0,0);   // load ignored in RUN
    add(1,0,0,1,6,5,0, 3,1,0,0);   // load and start ignored in RUN
    add(0,0,0,0,0,5,0, 3,1,0,0);
    add(0,0,0,0,0,5,0, 4,1,0,0);
    add(0,0,0,0,0,5,0, 4,1,0,0);
    add(0,0,0,0,0,5,0, 5,1,0,0);
    add(0,0,0,0,0,5,0, 5,1,0,0);
    add(0,0,0,0,0,5,0, 5,0,1,0);   // one-shot terminal at N+12
    add(0,0,0,0,0,5,0, 5,0,0,0);
    add(0,0,0,0,0,5,0, 5,0,0,0);
    add(1,0,0,0,0,5,0, 0,1,0,0);   // restart from DONE
    add(0,0,0,0,0,5,0, 0,1,0,0);
    add(0,0,0,0,0,5,0, 1,1,0,0);
    add(0,0,0,0,0,5,0, 1,1,0,0);
    add(0,0,0,0,0,5,0, 2,1,0,0);
    add(0,0,0,0,0,5,0, 2,1,0,0);
    for (int i = 0; i < 5; i++) add(0,0,1,0,0,5,0, 2,1,0,0);   // hold with divider at 1
    add(0,0,1,1,1,5,0, 1,1,0,0);   // load in HOLD
    add(0,0,1,0,0,5,0, 1,1,0,0);
    add(0,0,0,0,0,5,0, 1,1,0,0);   // release
    add(0,0,0,0,0,5,0, 2,1,0,0);   // frozen phase resumes: one cycle
    add(0,0,0,0,0,5,0, 2,1,0,0);
    add(0,0,0,0,0,5,0, 3,1,0,0);
    add(0,0,0,0,0,5,0, 3,1,0,0);
    add(0,0,0,0,0,5,0, 4,1,0,0);
    add(1,1,0,1,6,5,0, 0,0,0,0);   // stop+load+start at count 4
    add(1,0,0,0,0,3,1, 0,1,0,0);   // auto-reload run, term 3
    add(0,0,0,0,0,3,1, 0,1,0,0);
    add(0,0,0,0,0,3,1, 1,1,0,0);
    add(0,0,0,0,0,3,1, 1,1,0,0);
    add(0,0,0,0,0,3,1, 2,1,0,0);
    add(0,0,0,0,0,3,1, 2,1,0,0);
    add(0,0,0,0,0,3,1, 3,1,0,0);
    add(0,0,0,0,0,3,1, 3,1,0,0);
    add(0,0,0,0,0,3,1, 0,1,0,1);   // wrap 3->0
    add(0,0,0,0,0,3,1, 0,1,0,0);
    add(0,0,0,0,0,3,1, 1,1,0,0);
    add(0,0,0,0,0,3,1, 1,1,0,0);
    add(0,0,0,0,0,3,1, 2,1,0,0);
    add(0,0,0,0,0,1,1, 2,1,0,0);   // term drops below count
    add(0,0,0,0,0,1,1, 3,1,0,0);   // no match, keeps counting
    add(0,1,0,0,0,1,1, 0,0,0,0);

    #7;
    chk_a("reset_a", 0, 0, 0, 0);
    chk("reset_b.count", int'(if_b.count), 0);
    chk("reset_b.busy", int'(if_b.busy), 0);
`ifdef COUNT_SEQUENCER_IRQ_EN
    chk("reset.irq", int'(if_a.irq), 0);
`endif
    #15;
    RST = 1'b0;

    foreach (vecs[i]) begin
      if_a.start = vecs[i].start; if_a.stop = vecs[i].stop;
      if_a.hold = vecs[i].hold;   if_a.load = vecs[i].load;
      if_a.load_val = vecs[i].load_val; if_a.term_val = vecs[i].term_val;
      if_a.auto_rld = vecs[i].auto_rld;
      cyc();
      $display("vec %0d: count=%0d busy=%0b done=%0b wrap=%0b", i, if_a.count, if_a.busy, if_a.done, if_a.wrap);
      chk_a($sformatf("vec%0d", i), int'(vecs[i].e_count), int'(vecs[i].e_busy),
            int'(vecs[i].e_done), int'(vecs[i].e_wrap));
    end
    idle_a();

    // DIV=1: one tick per RUN cycle, wrap at 7->0
    if_b.start = 1;
    cyc();
    chk("div1.start.count", int'(if_b.count), 0);
    chk("div1.start.busy", int'(if_b.busy), 1);
    if_b.start = 0;
    for (int i = 1; i < 8; i++) begin
      cyc();
      $display("div1 step %0d: count=%0d wrap=%0b", i, if_b.count, if_b.wrap);
      chk($sformatf("div1.count%0d", i), int'(if_b.count), i);
      chk($sformatf("div1.wrap%0d", i), int'(if_b.wrap), 0);
    end
    cyc();
    chk("div1.wrap.count", int'(if_b.count), 0);
    chk("div1.wrap.pulse", int'(if_b.wrap), 1);
    chk("div1.wrap.done", int'(if_b.done), 0);
    cyc();
    chk("div1.after.count", int'(if_b.count), 1);
    chk("div1.after.wrap", int'(if_b.wrap), 0);
    if_b.stop = 1;
    cyc();
    if_b.stop = 0;
    chk("div1.stop.busy", int'(if_b.busy), 0);

    // Asynchronous reset between edges while running at count 3
    if_a.start = 1; if_a.term_val = 3'd7;
    cyc();
    if_a.start = 0;
    for (int i = 0; i < 6; i++) cyc();
    $display("pre-reset: count=%0d busy=%0b", if_a.count, if_a.busy);
    chk_a("prerst", 3, 1, 0, 0);
    #3;
    RST = 1'b1;
    #1;
    $display("async reset: count=%0d busy=%0b", if_a.count, if_a.busy);
    chk_a("asyncrst", 0, 0, 0, 0);
`ifdef COUNT_SEQUENCER_IRQ_EN
    chk("asyncrst.irq", int'(if_a.irq), 0);
`endif
    #2;
    RST = 1'b0;
    cyc();
    cyc();
    chk_a("postrst.idle", 0, 0, 0, 0);

`ifdef COUNT_SEQUENCER_IRQ_EN
    // One-shot to term 2 sets a sticky irq
    if_a.start = 1; if_a.term_val = 3'd2; if_a.auto_rld = 0;
    cyc();
    if_a.start = 0;
    for (int i = 0; i < 6; i++) cyc();
    $display("irq one-shot: count=%0d done=%0b irq=%0b", if_a.count, if_a.done, if_a.irq);
    chk_a("irq.done", 2, 0, 1, 0);
    chk("irq.set", int'(if_a.irq), 1);
    for (int i = 0; i < 3; i++) cyc();
    chk("irq.sticky", int'(if_a.irq), 1);
    // irq_clr coincident with a wrap pulse: set wins
    if_a.start = 1; if_a.term_val = 3'd1; if_a.auto_rld = 1;
    cyc();
    if_a.start = 0;
    cyc();
    cyc();
    chk("irq.run.count", int'(if_a.count), 1);
    cyc();
    if_a.irq_clr = 1;
    cyc();
    $display("irq clr+wrap: wrap=%0b irq=%0b", if_a.wrap, if_a.irq);
    chk("irq.clrwrap.wrap", int'(if_a.wrap), 1);
    chk("irq.clrwrap.irq", int'(if_a.irq), 1);
    cyc();
    chk("irq.cleared", int'(if_a.irq), 0);
    if_a.irq_clr = 0;
    if_a.stop = 1;
    cyc();
    idle_a();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
